// File: rtl/multiport_fifo_reader.sv
// multiport_fifo_reader
// Read-side adapter for the multi-port FIFO. Issues thermometer read bursts of
// up to LANES entries, packs the lanes that did not fail into a local buffer
// and replays them as a single-lane valid/ready stream in FIFO order.
//
// Ports:
//   clk, srst     clock and synchronous active-high reset
//   fifo_count    FIFO occupancy, used combinationally to size each burst
//   fifo_rd_en    per-lane read request (lanes 0..k-1), combinational
//   fifo_dout     returned data, lane i at [i*WIDTH +: WIDTH], valid one cycle after request
//   fifo_rd_fail  per-lane failure flag aligned with fifo_dout
//   m_data/m_valid/m_ready  registered single-beat output stream
//   err_count     saturating count of failed lanes
//
// Build option: define MPF_READER_ERRCNT_EN to implement err_count;
// otherwise err_count is tied to zero (failed lanes are still dropped).

module multiport_fifo_reader #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic [$clog2(DEPTH):0] fifo_count,
    output logic [LANES-1:0]       fifo_rd_en,
    input  logic [LANES*WIDTH-1:0] fifo_dout,
    input  logic [LANES-1:0]       fifo_rd_fail,
    output logic [WIDTH-1:0]       m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [15:0]            err_count
);

    localparam int unsigned KW = $clog2(LANES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t           state;
    logic [KW-1:0]    n_q;
    logic [KW-1:0]    head_q;
    logic [LANES-1:0] req_q;
    logic [WIDTH-1:0] beat_buf [LANES];

    logic [LANES-1:0] therm;
    logic             last_beat;
    logic             issue;
    logic [WIDTH-1:0] pack_buf [LANES];
    logic [KW-1:0]    pack_n;
    logic [WIDTH-1:0] next_data;

    // Lane i is requested when i < fifo_count; the loop bound caps the burst at LANES.
    always_comb begin
        therm = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (int'(fifo_count) > i) therm[i] = 1'b1;
        end
    end

    // Requests leave from IDLE or on the handshake of the final buffered beat.
    assign last_beat  = (state == ST_DRAIN) && m_ready && (head_q == n_q - KW'(1));
    assign issue      = !srst && (fifo_count != '0) && ((state == ST_IDLE) || last_beat);
    assign fifo_rd_en = issue ? therm : '0;

    // Compact the requested, non-failed lanes into ascending slots.
    always_comb begin
        pack_n = '0;
        for (int j = 0; j < int'(LANES); j++) pack_buf[j] = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (req_q[i] && !fifo_rd_fail[i]) begin
                for (int j = 0; j < int'(LANES); j++) begin
                    if (pack_n == KW'(j)) pack_buf[j] = fifo_dout[i*WIDTH +: WIDTH];
                end
                pack_n = pack_n + KW'(1);
            end
        end
    end

    // Beat following the one currently presented.
    always_comb begin
        next_data = '0;
        for (int j = 0; j < int'(LANES); j++) begin
            if (head_q + KW'(1) == KW'(j)) next_data = beat_buf[j];
        end
    end

    // Control FSM, buffer and registered output stream.
    always_ff @(posedge clk) begin
        if (srst) begin
            state   <= ST_IDLE;
            n_q     <= '0;
            head_q  <= '0;
            req_q   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            for (int j = 0; j < int'(LANES); j++) beat_buf[j] <= '0;
        end else begin
            req_q <= fifo_rd_en;
            case (state)
                ST_IDLE: begin
                    if (issue) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    for (int j = 0; j < int'(LANES); j++) beat_buf[j] <= pack_buf[j];
                    n_q    <= pack_n;
                    head_q <= '0;
                    if (pack_n != '0) begin
                        state   <= ST_DRAIN;
                        m_valid <= 1'b1;
                        m_data  <= pack_buf[0];
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (m_ready) begin
                        if (last_beat) begin
                            m_valid <= 1'b0;
                            head_q  <= '0;
                            state   <= issue ? ST_WAIT : ST_IDLE;
                        end else begin
                            head_q <= head_q + KW'(1);
                            m_data <= next_data;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MPF_READER_ERRCNT_EN
    logic [15:0]   err_q;
    logic [KW-1:0] fail_n;
    logic [16:0]   err_sum;

    // Failed lanes among those requested last cycle.
    always_comb begin
        fail_n = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (req_q[i] && fifo_rd_fail[i]) fail_n = fail_n + KW'(1);
        end
    end

    assign err_sum = {1'b0, err_q} + 17'(fail_n);

    // Saturating failure counter, updated once per WAIT cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            err_q <= '0;
        end else if (state == ST_WAIT) begin
            err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign err_count = err_q;
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_multiport_fifo_reader.sv
// Bench for multiport_fifo_reader: a queue-based FIFO model feeds the DUT, the
// driver pushes the expected surviving entries into a scoreboard, and a negedge
// monitor checks the output stream, the read requests and err_count.

module tb_multiport_fifo_reader;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LANES = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic                   clk = 1'b0;
    logic                   srst;
    logic [CW-1:0]          fifo_count;
    logic [LANES-1:0]       fifo_rd_en;
    logic [LANES*WIDTH-1:0] fifo_dout;
    logic [LANES-1:0]       fifo_rd_fail;
    logic [WIDTH-1:0]       m_data;
    logic                   m_valid;
    logic                   m_ready;
    logic [15:0]            err_count;

    always #5 clk = ~clk;

    multiport_fifo_reader #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .srst        (srst),
        .fifo_count  (fifo_count),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_dout   (fifo_dout),
        .fifo_rd_fail(fifo_rd_fail),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .err_count   (err_count)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] fq[$];
    int model_err = 0;
    int pend_fail = 0;
    int tot_fail  = 0;

    int fail_mode   = 0;   // 0 none, 1 random, 2 all, 3 fixed pattern
    logic [LANES-1:0] fix_fail = '0;
    int ready_mode  = 0;   // 0 always ready, 1 random, 2 held low
    int refill_mode = 0;   // 0 none, 1 random trickle, 2 keep full

    bit mon_en   = 0;
    bit prev_req = 0;
    bit exp_valid;
    bit exp_req;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic logic [LANES-1:0] therm_of(input int c);
        int k;
        k = (c > int'(LANES)) ? int'(LANES) : c;
        return LANES'((1 << k) - 1);
    endfunction

    function automatic int exp_err();
`ifdef MPF_READER_ERRCNT_EN
        return model_err;
`else
        return 0;
`endif
    endfunction

    // Monitor: output stream, request protocol and error counter.
    always @(negedge clk) begin
        if (mon_en) begin
            if (srst) begin
                chk("rd_en_in_reset", 64'(fifo_rd_en), 64'd0);
                sb.delete();
                prev_req = 0;
            end else begin
                exp_valid = (sb.size() > 0) && !prev_req;
                chk("m_valid", 64'(m_valid), 64'(exp_valid));
                if (m_valid && sb.size() > 0) chk("m_data", 64'(m_data), 64'(sb[0]));
                exp_req = !prev_req && (fifo_count != '0) &&
                          ((sb.size() == 0) || (sb.size() == 1 && m_valid && m_ready));
                chk("fifo_rd_en", 64'(fifo_rd_en), exp_req ? 64'(therm_of(int'(fifo_count))) : 64'd0);
                chk("err_count", 64'(err_count), 64'(exp_err()));
                if (m_valid && m_ready && sb.size() > 0) void'(sb.pop_front());
                prev_req = (fifo_rd_en != '0);
            end
        end
    end

    // One clock: serve the request seen this cycle, then update stimulus after the edge.
    task automatic step(input bit rst);
        logic [LANES-1:0] req;
        logic [WIDTH-1:0] d;
        bit f;
        @(negedge clk);
        req = fifo_rd_en;
        @(posedge clk);
        #1;
        if (srst) begin
            model_err = 0;
            pend_fail = 0;
        end else begin
            model_err = sat16(model_err + pend_fail);
            pend_fail = 0;
        end
        srst = rst;
        for (int i = 0; i < int'(LANES); i++) begin
            fifo_dout[i*WIDTH +: WIDTH] = $urandom;
            fifo_rd_fail[i] = 1'($urandom_range(0, 1));
            if (req[i] && fq.size() > 0) begin
                d = fq.pop_front();
                case (fail_mode)
                    1:       f = ($urandom_range(0, 3) == 0);
                    2:       f = 1'b1;
                    3:       f = fix_fail[i];
                    default: f = 1'b0;
                endcase
                fifo_dout[i*WIDTH +: WIDTH] = d;
                fifo_rd_fail[i] = f;
                if (!rst) begin
                    if (f) begin
                        pend_fail++;
                        tot_fail++;
                    end else begin
                        sb.push_back(d);
                    end
                end
            end
        end
        case (ready_mode)
            1:       m_ready = ($urandom_range(0, 2) != 0);
            2:       m_ready = 1'b0;
            default: m_ready = 1'b1;
        endcase
        if (refill_mode == 1 && $urandom_range(0, 3) == 0) begin
            for (int i = $urandom_range(1, 6); i > 0; i--)
                if (fq.size() < int'(DEPTH)) fq.push_back($urandom);
        end else if (refill_mode == 2) begin
            while (fq.size() < int'(DEPTH)) fq.push_back($urandom);
        end
        fifo_count = CW'(fq.size());
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) fq.push_back($urandom);
        fifo_count = CW'(fq.size());
    endtask

    task automatic run_idle(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            if (fq.size() == 0 && sb.size() == 0 && !m_valid && fifo_rd_en == '0) done = 1;
            else step(0);
        end
        chk("drain_timeout", 64'(done), 64'd1);
        repeat (2) step(0);
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        bit found;

        srst = 1'b1;
        fifo_count = '0;
        fifo_dout = '0;
        fifo_rd_fail = '0;
        m_ready = 1'b0;
        step(1);
        mon_en = 1;
        step(1);
        step(0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);

        // Three entries, one burst.
        load(3);
        run_idle(50);

        // Ten entries: bursts of 4, 4, 2.
        load(10);
        run_idle(80);

        // Lanes 0 and 2 fail.
        fail_mode = 3;
        fix_fail = 4'b0101;
        load(4);
        run_idle(50);
`ifdef MPF_READER_ERRCNT_EN
        chk("err_after_0101", 64'(err_count), 64'd2);
`else
        chk("err_after_0101", 64'(err_count), 64'd0);
`endif
        fail_mode = 0;

        // Backpressure mid-burst with more data waiting in the FIFO.
        load(8);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0);
            if (m_valid && sb.size() == 3) found = 1;
        end
        chk("bp_reach", 64'(found), 64'd1);
        ready_mode = 2;
        step(0);
        held = m_data;
        for (int i = 0; i < 5; i++) begin
            step(0);
            chk("bp_hold_data", 64'(m_data), 64'(held));
            chk("bp_no_read", 64'(fifo_rd_en), 64'd0);
        end
        ready_mode = 0;
        run_idle(80);

        // Reset while two beats remain.
        load(4);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0);
            if (m_valid && sb.size() == 2) found = 1;
        end
        chk("srst_reach", 64'(found), 64'd1);
        step(1);
        step(0);
        chk("srst_m_valid", 64'(m_valid), 64'd0);
        chk("srst_rd_en", 64'(fifo_rd_en), 64'd0);
        repeat (5) step(0);
        chk("srst_quiet", 64'(m_valid), 64'd0);

        // Randomized traffic with occasional resets.
        fail_mode = 1;
        ready_mode = 1;
        refill_mode = 1;
        for (int i = 0; i < 3000; i++) step($urandom_range(0, 299) == 0);
        refill_mode = 0;
        ready_mode = 0;
        run_idle(200);

        // Saturation: every lane fails until well past 65535.
        step(1);
        step(0);
        fail_mode = 2;
        refill_mode = 2;
        tot_fail = 0;
        for (int i = 0; i < 45000 && tot_fail < 70000; i++) step(0);
        chk("sat_reach", 64'(tot_fail >= 70000), 64'd1);
        refill_mode = 0;
        fq.delete();
        fifo_count = '0;
        repeat (4) step(0);
`ifdef MPF_READER_ERRCNT_EN
        chk("err_saturated", 64'(err_count), 64'hFFFF);
`else
        chk("err_saturated", 64'(err_count), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, actual=running expected=done");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multiport_fifo_reader.md
# multiport_fifo_reader

Read-side adapter for the multi-port FIFO: issues multi-lane read bursts (up to LANES entries per request) and presents the returned entries as a single-lane valid/ready stream in FIFO order. It sits between the FIFO's `rd_en`/`dout`/`rd_fail`/`data_count` ports and a single-beat consumer. It converts the FIFO's wide, non-first-word-fall-through read interface into one beat per cycle with backpressure.

## Interface
- `WIDTH`, 32, entry width in bits
- `LANES`, 4, FIFO read ports driven; legal range 1..8
- `DEPTH`, 16, FIFO depth; sets count width CW = $clog2(DEPTH)+1
- `clk`  in  1  clock; all logic on rising edge
- `srst`  in  1  synchronous, active-high reset
- `fifo_count`  in  CW  FIFO occupancy (`data_count`), sampled combinationally
- `fifo_rd_en`  out  LANES  per-lane read request; lane i set means "pop entry i"
- `fifo_dout`  in  LANES*WIDTH  returned data; lane i at bits [i*WIDTH +: WIDTH]
- `fifo_rd_fail`  in  LANES  per-lane failure flag, aligned with `fifo_dout`
- `m_data`  out  WIDTH  output beat
- `m_valid`  out  1  output beat valid
- `m_ready`  in  1  consumer accepts beat
- `err_count`  out  16  saturating count of failed lanes (see Configuration)

## Operation
- Internal buffer `buf[LANES]`, head index, fill count `n` (0..LANES), 3-state FSM.
- IDLE: buffer empty, `m_valid`=0. If `fifo_count`>0, set k = min(`fifo_count`, LANES) and drive `fifo_rd_en` as a thermometer: lanes 0..k-1 set, the rest 0. Hold it for exactly one cycle, then go to WAIT. If `fifo_count`=0, stay in IDLE with `fifo_rd_en`=0.
- WAIT: `fifo_dout`/`fifo_rd_fail` are valid this cycle for the lanes requested in the previous cycle.
  - Pack the requested lanes with `fifo_rd_fail`=0 into `buf[0..n-1]`, keeping ascending lane order.
  - Failed lanes are dropped and each one adds 1 to `err_count`.
  - n>0 goes to DRAIN with head=0; n=0 goes to IDLE.
  - `fifo_rd_en`=0 in WAIT.
- DRAIN: `m_valid`=1, `m_data`=`buf[head]`.
  - When `m_valid`&&`m_ready`, head increments.
  - On the handshake of the last beat (head=n-1): if `fifo_count`>0, issue the next thermometer request in that same cycle and go to WAIT; otherwise go to IDLE.
  - No other request is issued while the buffer holds data.
- Unrequested lanes of `fifo_dout`/`fifo_rd_fail` are ignored.
- `m_data` and `m_valid` are registered outputs and stay stable while `m_valid`&&!`m_ready`.

## Timing
- Reset values: `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `err_count`=0, state=IDLE, n=0, head=0.
- Latency: request in cycle t, capture at end of t+1, first `m_valid` in cycle t+2.
- Sustained throughput per burst of k: 1 beat/cycle while draining, plus a 1-cycle bubble (the WAIT cycle) between bursts.
- `m_ready` held low: the beat and the state hold indefinitely, and no FIFO reads are issued.
- `fifo_count` > LANES: the burst is capped at LANES. `fifo_count`=1: only lane 0 is requested.
- All requested lanes fail: no `m_valid` pulse; return to IDLE, then re-request the following cycle if `fifo_count`>0.
- `srst` mid-operation has priority over all transitions. Buffered entries and any in-flight WAIT data are discarded, which is a documented loss. The block is back in IDLE the next cycle.
- Arithmetic: k, n and head are $clog2(LANES)+1 bits wide. `err_count` increments by popcount(failed lanes) per WAIT cycle and saturates at 16'hFFFF.

## Configuration
- `MPF_READER_ERRCNT_EN` defined: the `err_count` counter is implemented as above.
- Not defined: no counter logic; `err_count` is tied to 0. Failed lanes are still dropped.

## Test plan
- Reset, then `fifo_count`=3 with LANES=4: `fifo_rd_en`=4'b0111 for one cycle. WAIT returns A,B,C with no failures. Then `m_valid` with A,B,C on 3 consecutive cycles, `m_ready`=1.
- `fifo_count`=10 with LANES=4, `m_ready`=1: requests 4, 4, 2. Output is the 10 beats in order, with a 1-cycle gap between bursts.
- Burst of 4 with `fifo_rd_fail`=4'b0101: output is lanes 1 and 3 only, in that order; `err_count`=2 (0 when `MPF_READER_ERRCNT_EN` is undefined).
- `m_ready` low for 5 cycles mid-burst: `m_data` stays stable, `fifo_rd_en` stays 0, and the remaining beats resume in order.
- Assert `srst` during DRAIN with 2 beats left: the next cycle has `m_valid`=0, `fifo_rd_en`=0, state IDLE. With `fifo_count`=0 thereafter, no further activity.
- Drive 70000 failed lanes: `err_count` saturates at 16'hFFFF.
